// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES controller types and constants
package aes_pkg;

  localparam int AES_NUM_ROUNDS = 10;

  typedef enum logic [2:0] {
    IDLE,
    EXPAND,
    SELECT,
    PRESENT,
    FINISH
  } key_seq_state_t;

  typedef logic [3:0] key_sel_t;

endpackage

// File: rtl/aes_round_key_sequencer.sv
// rtl/aes_round_key_sequencer.sv - round-key expander sequencing controller
module aes_round_key_sequencer
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS     = AES_NUM_ROUNDS,
  parameter int EXPAND_TIMEOUT = 64,
  parameter int SEL_W          = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             abort,
  input  logic             key_rdy,
  output logic             encrypt_en,
  output logic [SEL_W-1:0] key_sel,
  output logic             key_vld,
  input  logic             key_ack,
  output logic [SEL_W-1:0] round_no,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int               TMR_W    = $clog2(EXPAND_TIMEOUT + 1);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_ROUNDS);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(EXPAND_TIMEOUT);

  key_seq_state_t   state, state_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic             encrypt_en_nxt, key_vld_nxt, busy_nxt, done_nxt, err_nxt;
  logic [SEL_W-1:0] key_sel_nxt, round_no_nxt;

  // State and every output are registered together so outputs are glitch-free.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      timer      <= '0;
      encrypt_en <= 1'b0;
      key_sel    <= '0;
      key_vld    <= 1'b0;
      round_no   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      encrypt_en <= encrypt_en_nxt;
      key_sel    <= key_sel_nxt;
      key_vld    <= key_vld_nxt;
      round_no   <= round_no_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      err        <= err_nxt;
    end
  end

  // Next-state and next-output logic; abort overrides everything at the end.
  always_comb begin
    state_nxt      = state;
    timer_nxt      = timer;
    encrypt_en_nxt = encrypt_en;
    key_sel_nxt    = key_sel;
    key_vld_nxt    = key_vld;
    round_no_nxt   = round_no;
    done_nxt       = 1'b0;
    err_nxt        = err;

    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nxt      = EXPAND;
          encrypt_en_nxt = 1'b1;
          key_sel_nxt    = '0;
          round_no_nxt   = '0;
          err_nxt        = 1'b0;
          timer_nxt      = '0;
        end
      end
      EXPAND: begin
        if (timer != TMR_MAX) timer_nxt = timer + 1'b1;
        if (key_rdy) begin
          state_nxt = SELECT;
        end else if (timer_nxt == TMR_MAX) begin
          state_nxt      = IDLE;
          err_nxt        = 1'b1;
          encrypt_en_nxt = 1'b0;
          key_sel_nxt    = '0;
          round_no_nxt   = '0;
        end
      end
      SELECT: begin
        if (!key_rdy) begin
          state_nxt      = IDLE;
          err_nxt        = 1'b1;
          encrypt_en_nxt = 1'b0;
          key_vld_nxt    = 1'b0;
          key_sel_nxt    = '0;
          round_no_nxt   = '0;
        end else begin
          state_nxt   = PRESENT;
          key_vld_nxt = 1'b1;
        end
      end
      PRESENT: begin
        if (!key_rdy) begin
          state_nxt      = IDLE;
          err_nxt        = 1'b1;
          encrypt_en_nxt = 1'b0;
          key_vld_nxt    = 1'b0;
          key_sel_nxt    = '0;
          round_no_nxt   = '0;
        end else if (key_ack && key_vld) begin
          key_vld_nxt = 1'b0;
          if (round_no < LAST_SEL) begin
            state_nxt    = SELECT;
            key_sel_nxt  = key_sel + 1'b1;
            round_no_nxt = round_no + 1'b1;
          end else begin
            state_nxt = FINISH;
            done_nxt  = 1'b1;
          end
        end
      end
      FINISH: begin
        state_nxt      = IDLE;
        encrypt_en_nxt = 1'b0;
        key_sel_nxt    = '0;
        round_no_nxt   = '0;
      end
      default: begin
        state_nxt      = IDLE;
        encrypt_en_nxt = 1'b0;
        key_vld_nxt    = 1'b0;
        key_sel_nxt    = '0;
        round_no_nxt   = '0;
      end
    endcase

    if (abort && (state != IDLE)) begin
      state_nxt      = IDLE;
      timer_nxt      = timer;
      encrypt_en_nxt = 1'b0;
      key_vld_nxt    = 1'b0;
      key_sel_nxt    = '0;
      round_no_nxt   = '0;
      done_nxt       = 1'b0;
      err_nxt        = err;
    end

    busy_nxt = (state_nxt != IDLE);
  end

endmodule
